// File: rtl/bresenham_line.sv
// bresenham_line: integer Bresenham line walker.
// Latches two endpoints on a start pulse and emits one pixel per accepted
// valid/ready beat, from p toward q inclusive, then pulses done for one cycle.
// Optional build macro BRESEN_CLIP_EN: off-screen points (x>=SCREEN_W or
// y>=SCREEN_H) are stepped over internally without a handshake.
module bresenham_line #(
    parameter int COORD_W  = 10,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic [2*COORD_W-1:0]   p,
    input  logic [2*COORD_W-1:0]   q,
    output logic [2*COORD_W-1:0]   pixel,
    output logic                   pixel_valid,
    input  logic                   pixel_ready,
    output logic                   busy,
    output logic                   done
);

    // Error terms need two extra bits: one for sign, one for the 2*err product.
    localparam int EW = COORD_W + 2;

    localparam logic [COORD_W-1:0]   ONE_C  = {{(COORD_W-1){1'b0}}, 1'b1};
    localparam logic signed [EW-1:0] ZERO_E = '0;

    // Reject nonsensical screen extents at elaboration time.
    if (SCREEN_W <= 0 || SCREEN_H <= 0) begin : g_bad_screen
        $error("bresenham_line: SCREEN_W and SCREEN_H must be positive");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [COORD_W-1:0]     cur_x_q, cur_x_d;
    logic [COORD_W-1:0]     cur_y_q, cur_y_d;
    logic [COORD_W-1:0]     x1_q, x1_d;
    logic [COORD_W-1:0]     y1_q, y1_d;
    logic signed [EW-1:0]   dx_q, dx_d;
    logic signed [EW-1:0]   dy_q, dy_d;
    logic signed [EW-1:0]   err_q, err_d;
    logic                   sx_neg_q, sx_neg_d;
    logic                   sy_neg_q, sy_neg_d;

    logic                   at_end;
    logic                   on_screen;
    logic                   advance;
    logic signed [EW-1:0]   e2;
    logic                   step_x;
    logic                   step_y;
    logic signed [EW-1:0]   err_step;
    logic signed [EW-1:0]   setup_dx;
    logic signed [EW-1:0]   setup_dy;

    // Absolute difference of two unsigned coordinates as a signed error-width value.
    function automatic logic signed [EW-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                      input logic [COORD_W-1:0] b);
        logic signed [EW-1:0] d;
        d = $signed({2'b00, a}) - $signed({2'b00, b});
        return (d < ZERO_E) ? -d : d;
    endfunction

    // Per-cycle walk decisions derived from the current position and error term.
    always_comb begin
        at_end   = (cur_x_q == x1_q) && (cur_y_q == y1_q);
`ifdef BRESEN_CLIP_EN
        on_screen = (32'(cur_x_q) < SCREEN_W) && (32'(cur_y_q) < SCREEN_H);
`else
        on_screen = 1'b1;
`endif
        // Off-screen points advance without waiting for the consumer.
        advance  = on_screen ? pixel_ready : 1'b1;
        e2       = err_q <<< 1;
        step_x   = (e2 >= dy_q);
        step_y   = (e2 <= dx_q);
        err_step = err_q + (step_x ? dy_q : ZERO_E) + (step_y ? dx_q : ZERO_E);
        setup_dx = abs_diff(x1_q, cur_x_q);
        setup_dy = -abs_diff(y1_q, cur_y_q);
    end

    // Next-state and datapath update for the IDLE/SETUP/DRAW/DONE sequence.
    always_comb begin
        state_d  = state_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // The start point is loaded straight into the walk position.
                    cur_x_d = p[2*COORD_W-1:COORD_W];
                    cur_y_d = p[COORD_W-1:0];
                    x1_d    = q[2*COORD_W-1:COORD_W];
                    y1_d    = q[COORD_W-1:0];
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                dx_d     = setup_dx;
                dy_d     = setup_dy;
                sx_neg_d = !(cur_x_q < x1_q);
                sy_neg_d = !(cur_y_q < y1_q);
                err_d    = setup_dx + setup_dy;
                state_d  = S_DRAW;
            end
            S_DRAW: begin
                if (advance) begin
                    if (at_end) begin
                        state_d = S_DONE;
                    end else begin
                        err_d = err_step;
                        if (step_x) begin
                            cur_x_d = sx_neg_q ? (cur_x_q - ONE_C) : (cur_x_q + ONE_C);
                        end
                        if (step_y) begin
                            cur_y_d = sy_neg_q ? (cur_y_q - ONE_C) : (cur_y_q + ONE_C);
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and walk registers; everything clears on reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
        end
    end

    // Outputs are decoded directly from registered state.
    always_comb begin
        pixel       = {cur_x_q, cur_y_q};
        pixel_valid = (state_q == S_DRAW) && on_screen;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_bresenham_line.sv
// Directed testbench for bresenham_line: table of lines with hand-computed
// pixel sequences, plus reset-during-draw and screen-edge sequences.
module tb_bresenham_line;

    localparam int CW = 10;

    logic            clk = 1'b0;
    logic            n_rst;
    logic            start;
    logic [2*CW-1:0] p;
    logic [2*CW-1:0] q;
    logic [2*CW-1:0] pixel;
    logic            pixel_valid;
    logic            pixel_ready;
    logic            busy;
    logic            done;

    int n_checks = 0;
    int n_fail   = 0;

    bresenham_line #(.COORD_W(CW), .SCREEN_W(640), .SCREEN_H(480)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .p           (p),
        .q           (q),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*CW-1:0] p;
        logic [2*CW-1:0] q;
        int              n;
        logic [2*CW-1:0] pix[8];
        bit              stall;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [2*CW-1:0] pt(input int x, input int y);
        return {x[CW-1:0], y[CW-1:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one line and check every beat, the done pulse and the return to IDLE.
    task automatic run_line(input vec_t v, input string tag);
        int k;
        int cyc;
        bit rdy;
        @(negedge clk);
        p = v.p; q = v.q; start = 1'b1; pixel_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " setup busy"}, 32'(busy), 32'd1);
        chk({tag, " setup valid"}, 32'(pixel_valid), 32'd0);
        @(negedge clk);
        k = 0;
        cyc = 0;
        while (k < v.n && cyc < 64) begin
            rdy = v.stall ? (cyc % 3 == 0) : 1'b1;
            pixel_ready = rdy;
            chk({tag, " valid"}, 32'(pixel_valid), 32'd1);
            chk({tag, " pixel"}, 32'(pixel), 32'(v.pix[k]));
            chk({tag, " no early done"}, 32'(done), 32'd0);
            // A start while drawing must be ignored.
            start = v.stall && (cyc == 1);
            if (start) begin
                p = pt(50, 50); q = pt(60, 70);
            end
            @(negedge clk);
            if (rdy) k++;
            cyc++;
        end
        start = 1'b0;
        chk({tag, " beats within budget"}, 32'(k), 32'(v.n));
        chk({tag, " done pulse"}, 32'(done), 32'd1);
        chk({tag, " done valid low"}, 32'(pixel_valid), 32'd0);
        chk({tag, " done busy"}, 32'(busy), 32'd1);
        // start during DONE is ignored.
        start = 1'b1; p = pt(7, 7); q = pt(8, 8);
        @(negedge clk);
        start = 1'b0;
        chk({tag, " done one cycle"}, 32'(done), 32'd0);
        chk({tag, " idle after done"}, 32'(busy), 32'd0);
        pixel_ready = 1'b1;
    endtask

    initial begin
        int k;
        bit seen_done;
        int n6;

        tbl[0].p = pt(0, 0); tbl[0].q = pt(5, 0); tbl[0].n = 6; tbl[0].stall = 1'b0;
        tbl[0].pix = '{pt(0,0), pt(1,0), pt(2,0), pt(3,0), pt(4,0), pt(5,0), 0, 0};
        tbl[1].p = pt(3, 7); tbl[1].q = pt(0, 2); tbl[1].n = 6; tbl[1].stall = 1'b0;
        tbl[1].pix = '{pt(3,7), pt(2,6), pt(2,5), pt(1,4), pt(1,3), pt(0,2), 0, 0};
        tbl[2].p = pt(9, 9); tbl[2].q = pt(9, 9); tbl[2].n = 1; tbl[2].stall = 1'b0;
        tbl[2].pix = '{pt(9,9), 0, 0, 0, 0, 0, 0, 0};
        tbl[3].p = pt(0, 0); tbl[3].q = pt(4, 4); tbl[3].n = 5; tbl[3].stall = 1'b1;
        tbl[3].pix = '{pt(0,0), pt(1,1), pt(2,2), pt(3,3), pt(4,4), 0, 0, 0};
        tbl[4].p = pt(2, 1); tbl[4].q = pt(6, 3); tbl[4].n = 5; tbl[4].stall = 1'b0;
        tbl[4].pix = '{pt(2,1), pt(3,2), pt(4,2), pt(5,3), pt(6,3), 0, 0, 0};
        tbl[5].p = pt(1, 0); tbl[5].q = pt(0, 3); tbl[5].n = 4; tbl[5].stall = 1'b0;
        tbl[5].pix = '{pt(1,0), pt(1,1), pt(0,2), pt(0,3), 0, 0, 0, 0};

        n_rst = 1'b0; start = 1'b0; p = '0; q = '0; pixel_ready = 1'b1;
        #1;
        chk("reset pixel", 32'(pixel), 32'd0);
        chk("reset valid", 32'(pixel_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_line(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a long line.
        @(negedge clk);
        p = pt(0, 0); q = pt(100, 50); start = 1'b1; pixel_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid-draw valid", 32'(pixel_valid), 32'd1);
        n_rst = 1'b0;
        #1;
        chk("async rst pixel", 32'(pixel), 32'd0);
        chk("async rst valid", 32'(pixel_valid), 32'd0);
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst done", 32'(done), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        chk("no activity after rst", 32'(seen_done), 32'd0);
        run_line(tbl[0], "post-rst");

        // Line crossing the right screen edge.
`ifdef BRESEN_CLIP_EN
        n6 = 4;
`else
        n6 = 8;
`endif
        @(negedge clk);
        p = pt(636, 0); q = pt(643, 0); start = 1'b1; pixel_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            if (pixel_valid) begin
                chk("edge pixel", 32'(pixel), 32'(pt(636 + k, 0)));
                k++;
            end
            if (done) seen_done = 1'b1;
            else @(negedge clk);
        end
        chk("edge pixel count", 32'(k), 32'(n6));
        chk("edge done seen", 32'(seen_done), 32'd1);
        @(negedge clk);
        chk("edge idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
